// File: rtl/boid_frame_writer_pkg.sv
// Shared constants, derived widths and FSM state encoding for the boid display path.
package boid_frame_writer_pkg;

  // Visible raster and flock size defaults.
  localparam int VIDEO_WIDTH_DEF  = 640;
  localparam int VIDEO_HEIGHT_DEF = 480;
  localparam int MAX_BOIDS_DEF    = 16;

  // Widths derived from the defaults above.
  localparam int BOID_BITS_DEF  = $clog2(MAX_BOIDS_DEF);
  localparam int ADDR_WIDTH_DEF = $clog2(VIDEO_WIDTH_DEF * VIDEO_HEIGHT_DEF);

  // Boid coordinate widths, plus one bit for the sprite offset overflow.
  localparam int X_W  = 10;
  localparam int Y_W  = 9;
  localparam int PX_W = X_W + 1;
  localparam int PY_W = Y_W + 1;

  // Skip counter width and saturation value.
  localparam int         SKIP_W   = 8;
  localparam logic [7:0] SKIP_MAX = 8'hFF;

  // Frame writer FSM states.
  typedef enum logic [2:0] {
    IDLE,
    SWAP,
    FETCH,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/boid_frame_writer_pixel_addr_calc.sv
// Pixel position to linear frame-buffer address, with visible-area range check.
module pixel_addr_calc
  import boid_frame_writer_pkg::*;
#(
  parameter int VIDEO_WIDTH  = VIDEO_WIDTH_DEF,
  parameter int VIDEO_HEIGHT = VIDEO_HEIGHT_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic                  dx,
  input  logic                  dy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range
);

  localparam logic [PX_W-1:0] X_LIMIT = PX_W'(VIDEO_WIDTH);
  localparam logic [PY_W-1:0] Y_LIMIT = PY_W'(VIDEO_HEIGHT);

  logic [PX_W-1:0] px;
  logic [PY_W-1:0] py;

  // Sprite offset is added with one spare bit so x=1023/y=511 cannot wrap into range.
  assign px = {1'b0, x} + {{(PX_W-1){1'b0}}, dx};
  assign py = {1'b0, y} + {{(PY_W-1){1'b0}}, dy};

  // py*640 as py*512 + py*128, so no multiplier is needed.
  assign addr = (ADDR_WIDTH'(py) << 9) + (ADDR_WIDTH'(py) << 7) + ADDR_WIDTH'(px);

  assign in_range = (px < X_LIMIT) && (py < Y_LIMIT);

endmodule

// File: rtl/boid_frame_writer.sv
// Scans every boid once per frame and plots it (1 or 2x2 pixels) into a cleared frame buffer.
module boid_frame_writer
  import boid_frame_writer_pkg::*;
#(
  parameter int MAX_BOIDS    = MAX_BOIDS_DEF,
  parameter int BOID_BITS    = BOID_BITS_DEF,
  parameter int VIDEO_WIDTH  = VIDEO_WIDTH_DEF,
  parameter int VIDEO_HEIGHT = VIDEO_HEIGHT_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int SPRITE_2X2   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  screen_end,
  output logic [BOID_BITS-1:0]  boid_sel,
  input  logic [X_W-1:0]        boid_x,
  input  logic [Y_W-1:0]        boid_y,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_data,
  output logic                  fb_swap,
  output logic                  busy,
  output logic                  frame_done,
  output logic [SKIP_W-1:0]     skip_count,
  output logic                  missed_frame
);

  localparam logic [BOID_BITS-1:0] LAST_IDX = BOID_BITS'(MAX_BOIDS - 1);

  state_t               state;
  state_t               state_next;
  logic [BOID_BITS-1:0] idx;
  logic [1:0]           sub;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic                 last_sub;
  logic                 pix_in_range;
  logic [ADDR_WIDTH-1:0] pix_addr;

  // Single-pixel mode finishes a boid in one WRITE cycle; the sprite needs all four.
  assign last_sub = (SPRITE_2X2 != 0) ? (sub == 2'd3) : 1'b1;

  pixel_addr_calc #(
    .VIDEO_WIDTH (VIDEO_WIDTH),
    .VIDEO_HEIGHT(VIDEO_HEIGHT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_pixel_addr_calc (
    .x       (x_q),
    .y       (y_q),
    .dx      (sub[0]),
    .dy      (sub[1]),
    .addr    (pix_addr),
    .in_range(pix_in_range)
  );

  // Write port is a function of registered state only; the boid inputs go through x_q/y_q.
  assign fb_we    = (state == WRITE) && pix_in_range;
  assign fb_addr  = (state == WRITE) ? pix_addr : '0;
  assign fb_data  = 1'b1;
  assign busy     = (state != IDLE);
  // The index only moves between frames or when a new FETCH begins, so it holds outside FETCH.
  assign boid_sel = idx;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and one-cycle strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    fb_swap    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (screen_end) state_next = SWAP;
      SWAP: begin
        fb_swap    = 1'b1;
        state_next = FETCH;
      end
      FETCH: state_next = WRITE;
      WRITE: if (last_sub) state_next = (idx == LAST_IDX) ? DONE : FETCH;
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Boid index, sub-pixel counter, position capture and clip counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      sub        <= 2'd0;
      x_q        <= '0;
      y_q        <= '0;
      skip_count <= '0;
    end else begin
      case (state)
        SWAP: begin
          idx        <= '0;
          sub        <= 2'd0;
          skip_count <= '0;
        end
        FETCH: begin
          x_q <= boid_x;
          y_q <= boid_y;
          sub <= 2'd0;
        end
        WRITE: begin
          if (!pix_in_range && (skip_count != SKIP_MAX)) skip_count <= skip_count + 8'd1;
          if (last_sub) begin
            sub <= 2'd0;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end else begin
            sub <= sub + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky flag: a frame start arrived while the previous frame was still being drawn.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            missed_frame <= 1'b0;
    else if (screen_end && state != IDLE) missed_frame <= 1'b1;
  end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed table-driven bench for boid_frame_writer: sprite and single-pixel instances.
module tb_boid_frame_writer;

  logic        clk = 1'b0;
  logic        reset;

  // Default (2x2 sprite) instance signals.
  logic        screen_end;
  logic [3:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        fb_we, fb_data, fb_swap, busy, frame_done, missed_frame;
  logic [18:0] fb_addr;
  logic [7:0]  skip_count;

  // Single-pixel instance signals.
  logic        screen_end_s;
  logic [3:0]  boid_sel_s;
  logic [9:0]  boid_x_s;
  logic [8:0]  boid_y_s;
  logic        fb_we_s, fb_data_s, fb_swap_s, busy_s, frame_done_s, missed_frame_s;
  logic [18:0] fb_addr_s;
  logic [7:0]  skip_count_s;

  // Boid position memories answering boid_sel in the same cycle.
  logic [9:0]  pos_x   [16];
  logic [8:0]  pos_y   [16];
  logic [9:0]  pos_x_s [16];
  logic [8:0]  pos_y_s [16];

  assign boid_x   = pos_x[boid_sel];
  assign boid_y   = pos_y[boid_sel];
  assign boid_x_s = pos_x_s[boid_sel_s];
  assign boid_y_s = pos_y_s[boid_sel_s];

  always #5 clk = ~clk;

  boid_frame_writer dut (
    .clock(clk), .reset(reset), .screen_end(screen_end),
    .boid_sel(boid_sel), .boid_x(boid_x), .boid_y(boid_y),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_swap(fb_swap),
    .busy(busy), .frame_done(frame_done), .skip_count(skip_count),
    .missed_frame(missed_frame)
  );

  boid_frame_writer #(.SPRITE_2X2(0)) dut_s (
    .clock(clk), .reset(reset), .screen_end(screen_end_s),
    .boid_sel(boid_sel_s), .boid_x(boid_x_s), .boid_y(boid_y_s),
    .fb_we(fb_we_s), .fb_addr(fb_addr_s), .fb_data(fb_data_s), .fb_swap(fb_swap_s),
    .busy(busy_s), .frame_done(frame_done_s), .skip_count(skip_count_s),
    .missed_frame(missed_frame_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame record: boid0 position, position of boids 1..15, optional re-pulse cycle,
  // and the hand-computed write list, clip count and missed flag.
  typedef struct {
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  xr;
    logic [8:0]  yr;
    int          inject;
    int          exp_n;
    logic [18:0] a0, a1, a2, a3;
    logic [7:0]  exp_skip;
    logic        exp_missed;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vec [NVEC];

  // Observations from the most recent frame.
  int          wr_n, swap_n, swap_at, done_n, done_at;
  logic [18:0] wr_addr [64];
  logic [7:0]  skip_at_done, skip_after_swap;

  // Cycle 0 is the cycle in which screen_end is high; SWAP is cycle 1.
  // Frame length 2 + 16*(1+4) = 82 puts DONE in cycle 82.
  task automatic run_frame(input int inject);
    wr_n = 0; swap_n = 0; swap_at = -1; done_n = 0; done_at = -1;
    skip_at_done = 8'hxx; skip_after_swap = 8'hxx;
    @(negedge clk);
    screen_end = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      screen_end = (c == inject);
      if (fb_swap) begin swap_n++; swap_at = c; end
      if (fb_we) begin
        if (wr_n < 64) wr_addr[wr_n] = fb_addr;
        wr_n++;
      end
      if (frame_done) begin done_n++; done_at = c; skip_at_done = skip_count; end
      if (c == 2) skip_after_swap = skip_count;
    end
    screen_end = 1'b0;
  endtask

  task automatic set_positions(input logic [9:0] x0, input logic [8:0] y0,
                               input logic [9:0] xr, input logic [8:0] yr);
    pos_x[0] = x0; pos_y[0] = y0;
    for (int i = 1; i < 16; i++) begin pos_x[i] = xr; pos_y[i] = yr; end
  endtask

  initial begin
    int n_we, n_sw;
    vec[0] = '{10'd10,  9'd10,  10'd700,  9'd0,   -1, 4, 19'd6410,   19'd6411,   19'd7050,   19'd7051,   8'd60, 1'b0};
    vec[1] = '{10'd639, 9'd479, 10'd700,  9'd0,   -1, 1, 19'd307199, 19'd0,      19'd0,      19'd0,      8'd63, 1'b0};
    vec[2] = '{10'd0,   9'd0,   10'd700,  9'd0,   -1, 4, 19'd0,      19'd1,      19'd640,    19'd641,    8'd60, 1'b0};
    vec[3] = '{10'd638, 9'd478, 10'd700,  9'd0,   -1, 4, 19'd306558, 19'd306559, 19'd307198, 19'd307199, 8'd60, 1'b0};
    vec[4] = '{10'd700, 9'd0,   10'd700,  9'd0,   -1, 0, 19'd0,      19'd0,      19'd0,      19'd0,      8'd64, 1'b0};
    vec[5] = '{10'd0,   9'd480, 10'd0,    9'd480, -1, 0, 19'd0,      19'd0,      19'd0,      19'd0,      8'd64, 1'b0};
    vec[6] = '{10'd1023,9'd511, 10'd1023, 9'd511, -1, 0, 19'd0,      19'd0,      19'd0,      19'd0,      8'd64, 1'b0};
    vec[7] = '{10'd640, 9'd0,   10'd640,  9'd0,   -1, 0, 19'd0,      19'd0,      19'd0,      19'd0,      8'd64, 1'b0};
    vec[8] = '{10'd10,  9'd10,  10'd700,  9'd0,   20, 4, 19'd6410,   19'd6411,   19'd7050,   19'd7051,   8'd60, 1'b1};

    for (int i = 0; i < 16; i++) begin
      pos_x_s[i] = 10'(i); pos_y_s[i] = 9'd0;
    end
    set_positions(10'd0, 9'd0, 10'd0, 9'd0);
    screen_end = 1'b0; screen_end_s = 1'b0;

    // Power-on reset.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst fb_we", fb_we, 0);
    check("rst fb_addr", fb_addr, 0);
    check("rst fb_swap", fb_swap, 0);
    check("rst frame_done", frame_done, 0);
    check("rst skip_count", skip_count, 0);
    check("rst missed", missed_frame, 0);
    check("rst boid_sel", boid_sel, 0);
    check("rst fb_data", fb_data, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames on the sprite instance.
    for (int r = 0; r < NVEC; r++) begin
      set_positions(vec[r].x0, vec[r].y0, vec[r].xr, vec[r].yr);
      run_frame(vec[r].inject);
      check($sformatf("row%0d swap_count", r), swap_n, 1);
      check($sformatf("row%0d swap_cycle", r), swap_at, 1);
      check($sformatf("row%0d done_count", r), done_n, 1);
      check($sformatf("row%0d done_cycle", r), done_at, 82);
      check($sformatf("row%0d writes", r), wr_n, vec[r].exp_n);
      if (vec[r].exp_n > 0 && wr_n > 0) check($sformatf("row%0d addr0", r), wr_addr[0], vec[r].a0);
      if (vec[r].exp_n > 1 && wr_n > 1) check($sformatf("row%0d addr1", r), wr_addr[1], vec[r].a1);
      if (vec[r].exp_n > 2 && wr_n > 2) check($sformatf("row%0d addr2", r), wr_addr[2], vec[r].a2);
      if (vec[r].exp_n > 3 && wr_n > 3) check($sformatf("row%0d addr3", r), wr_addr[3], vec[r].a3);
      check($sformatf("row%0d skip_done", r), skip_at_done, vec[r].exp_skip);
      check($sformatf("row%0d skip_cleared", r), skip_after_swap, 0);
      check($sformatf("row%0d missed", r), missed_frame, vec[r].exp_missed);
      check($sformatf("row%0d idle_busy", r), busy, 0);
      check($sformatf("row%0d sel_hold", r), boid_sel, 15);
    end

    // Reset in the middle of a frame (cycle 30, boid 5 being written).
    set_positions(10'd10, 9'd10, 10'd700, 9'd0);
    @(negedge clk);
    screen_end = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      screen_end = 1'b0;
    end
    check("mid busy_before", busy, 1);
    check("mid sel_before", boid_sel, 5);
    reset = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst fb_we", fb_we, 0);
    check("mid rst fb_addr", fb_addr, 0);
    check("mid rst fb_swap", fb_swap, 0);
    check("mid rst frame_done", frame_done, 0);
    check("mid rst skip", skip_count, 0);
    check("mid rst missed", missed_frame, 0);
    check("mid rst boid_sel", boid_sel, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_we = 0; n_sw = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fb_we) n_we++;
      if (fb_swap) n_sw++;
    end
    check("aborted writes", n_we, 0);
    check("aborted swaps", n_sw, 0);
    run_frame(-1);
    check("restart writes", wr_n, 4);
    if (wr_n > 0) check("restart addr0", wr_addr[0], 19'd6410);
    check("restart done_cycle", done_at, 82);
    check("restart skip", skip_at_done, 60);

    // Single-pixel instance: boids at (0,0)..(15,0); DONE at 2 + 16*2 = 34.
    wr_n = 0; swap_at = -1; done_at = -1; swap_n = 0; done_n = 0;
    @(negedge clk);
    screen_end_s = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      screen_end_s = 1'b0;
      if (fb_swap_s) begin swap_n++; swap_at = c; end
      if (fb_we_s) begin
        if (wr_n < 64) wr_addr[wr_n] = fb_addr_s;
        wr_n++;
      end
      if (frame_done_s) begin done_n++; done_at = c; skip_at_done = skip_count_s; end
    end
    check("s1 swap_cycle", swap_at, 1);
    check("s1 done_count", done_n, 1);
    check("s1 done_cycle", done_at, 34);
    check("s1 writes", wr_n, 16);
    for (int k = 0; k < 16; k++)
      if (k < wr_n) check($sformatf("s1 addr%0d", k), wr_addr[k], 19'(k));
    check("s1 skip", skip_at_done, 0);
    check("s1 missed", missed_frame_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
